axi_rt_unit_counter_multi: RTL and testbench

Multi-channel successor to the single-channel RT budget/period counter. One shared period timer feeds NumChannels independent byte-budget counters, e.g. channel 0 = AW and channel 1 = AR of one manager. Adds four things:
- saturating (non-wrapping) budget arithmetic;
- optional per-channel carry-over of unused budget;
- a sticky per-channel overrun flag;
- a period-over pulse.

Sits in the RT unit between the AX snoop logic and the regulation/gating logic.

---
 rtl/axi_rt_unit_counter_multi.sv | 170 +++++++++++++++++
 tb/tb_axi_rt_unit_counter_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rt_unit_counter_multi.sv
// -----------------------------------------------------------------------------
// axi_rt_unit_counter_multi
//
// Real-time regulation counter with a shared period timer and several
// independent byte-budget channels (e.g. channel 0 = AW, channel 1 = AR of one
// manager). Each period, every channel is refilled with its budget (or has the
// budget added to what is left, saturating, when carry-over is enabled).
// Accepted transactions are charged against the remaining budget with
// saturating subtraction. A sticky overrun flag records that a transaction
// asked for more bytes than were left in the current period.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous active-high reset
//   enable_i         global enable for period countdown and budget consumption
//   period_i         period reload value
//   period_abort_i   force a period reload this cycle (independent of enable_i)
//   period_left_o    remaining cycles in the current period
//   period_over_o    one-cycle pulse, the cycle after a reload took place
//   budget_i         per-channel budget per period
//   carry_en_i       per-channel carry-over of unused budget
//   ax_happening_i   transaction accepted on channel this cycle
//   ax_bytes_i       byte count of that transaction
//   budget_left_o    remaining budget per channel
//   budget_spent_o   per channel: remaining budget is zero
//   budget_overrun_o per channel: sticky, a transaction exceeded the budget left
// -----------------------------------------------------------------------------
module axi_rt_unit_counter_multi #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BudgetWidth = 32,
  parameter int unsigned BytesWidth  = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   enable_i,
  input  logic [PeriodWidth-1:0]                 period_i,
  input  logic                                   period_abort_i,
  output logic [PeriodWidth-1:0]                 period_left_o,
  output logic                                   period_over_o,
  input  logic [NumChannels-1:0][BudgetWidth-1:0] budget_i,
  input  logic [NumChannels-1:0]                 carry_en_i,
  input  logic [NumChannels-1:0]                 ax_happening_i,
  input  logic [NumChannels-1:0][BytesWidth-1:0] ax_bytes_i,
  output logic [NumChannels-1:0][BudgetWidth-1:0] budget_left_o,
  output logic [NumChannels-1:0]                 budget_spent_o,
  output logic [NumChannels-1:0]                 budget_overrun_o
);

  // Width wide enough to compare a byte count with a budget without losing
  // any bits on either side.
  localparam int unsigned CmpW = (BudgetWidth > BytesWidth) ? BudgetWidth : BytesWidth;

  // Budget + budget, clamped at all-ones instead of wrapping.
  function automatic logic [BudgetWidth-1:0] sat_add(
    input logic [BudgetWidth-1:0] a,
    input logic [BudgetWidth-1:0] b
  );
    logic [BudgetWidth:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[BudgetWidth]) begin
      return '1;
    end
    return sum[BudgetWidth-1:0];
  endfunction

  // True when the transaction asks for more bytes than the base holds.
  function automatic logic exceeds(
    input logic [BytesWidth-1:0]  bytes,
    input logic [BudgetWidth-1:0] base
  );
    return CmpW'(bytes) > CmpW'(base);
  endfunction

  // Budget - bytes, clamped at zero. When no clamping happens the difference
  // is no larger than the base, so narrowing back to BudgetWidth is lossless.
  function automatic logic [BudgetWidth-1:0] sat_sub(
    input logic [BudgetWidth-1:0] base,
    input logic [BytesWidth-1:0]  bytes
  );
    logic [CmpW-1:0] diff;
    if (exceeds(bytes, base)) begin
      return '0;
    end
    diff = CmpW'(base) - CmpW'(bytes);
    return BudgetWidth'(diff);
  endfunction

  logic [PeriodWidth-1:0]                  period_q, period_d;
  logic                                    over_q;
  logic                                    reload;
  logic [NumChannels-1:0][BudgetWidth-1:0] budget_q, budget_d, base;
  logic [NumChannels-1:0]                  overrun_q, overrun_d;
  logic [NumChannels-1:0]                  consume;

  // ---- period timer: next-state --------------------------------------------
  // An abort reloads even while disabled; a natural expiry needs enable_i.
  assign reload = period_abort_i | (enable_i & (period_q == '0));

  always_comb begin
    period_d = period_q;
    if (reload) begin
      period_d = period_i;
    end else if (enable_i) begin
      period_d = period_q - PeriodWidth'(1);
    end
  end

  // ---- budget channels: next-state -----------------------------------------
  // consume looks at the spent flag of the current (pre-reload) budget, so a
  // transaction seen while spent is never charged, even on a reload cycle.
  // When reload and consume coincide, the charge goes against the new base.
  always_comb begin
    consume   = '0;
    base      = '0;
    budget_d  = '0;
    overrun_d = '0;
    for (int c = 0; c < NumChannels; c++) begin
      consume[c] = enable_i & ax_happening_i[c] & ~budget_spent_o[c];

      if (!reload) begin
        base[c] = budget_q[c];
      end else if (carry_en_i[c]) begin
        base[c] = sat_add(budget_q[c], budget_i[c]);
      end else begin
        base[c] = budget_i[c];
      end

      budget_d[c] = consume[c] ? sat_sub(base[c], ax_bytes_i[c]) : base[c];

      // A new overrun wins over the reload clear in the same cycle.
      if (consume[c] && exceeds(ax_bytes_i[c], base[c])) begin
        overrun_d[c] = 1'b1;
      end else if (reload) begin
        overrun_d[c] = 1'b0;
      end else begin
        overrun_d[c] = overrun_q[c];
      end
    end
  end

  // ---- state registers ------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q  <= '0;
      over_q    <= 1'b0;
      budget_q  <= '0;
      overrun_q <= '0;
    end else begin
      period_q  <= period_d;
      over_q    <= reload;
      budget_q  <= budget_d;
      overrun_q <= overrun_d;
    end
  end

  // ---- outputs --------------------------------------------------------------
  always_comb begin
    budget_spent_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      budget_spent_o[c] = (budget_q[c] == '0);
    end
  end

  assign period_left_o    = period_q;
  assign period_over_o    = over_q;
  assign budget_left_o    = budget_q;
  assign budget_overrun_o = overrun_q;

endmodule

// File: tb/tb_axi_rt_unit_counter_multi.sv
// Directed bench for axi_rt_unit_counter_multi with two channels.
module tb_axi_rt_unit_counter_multi;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [31:0]           per;
  logic                  abort;
  logic [31:0]           per_left;
  logic                  over;
  logic [1:0][31:0]      bud;
  logic [1:0]            carry;
  logic [1:0]            ax;
  logic [1:0][15:0]      bytes;
  logic [1:0][31:0]      bleft;
  logic [1:0]            spent;
  logic [1:0]            ovr;

  int nchk = 0;
  int nerr = 0;

  axi_rt_unit_counter_multi #(
    .NumChannels(2),
    .PeriodWidth(32),
    .BudgetWidth(32),
    .BytesWidth(16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (en),
    .period_i         (per),
    .period_abort_i   (abort),
    .period_left_o    (per_left),
    .period_over_o    (over),
    .budget_i         (bud),
    .carry_en_i       (carry),
    .ax_happening_i   (ax),
    .ax_bytes_i       (bytes),
    .budget_left_o    (bleft),
    .budget_spent_o   (spent),
    .budget_overrun_o (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        abort;
    logic [31:0] per;
    logic [31:0] bud0;
    logic [31:0] bud1;
    logic [1:0]  carry;
    logic [1:0]  ax;
    logic [15:0] by0;
    logic [15:0] by1;
    logic [31:0] e_per;
    logic [31:0] e_b0;
    logic [31:0] e_b1;
    logic        e_over;
    logic [1:0]  e_spent;
    logic [1:0]  e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic ab, input logic [31:0] p,
                     input logic [31:0] b0, input logic [31:0] b1,
                     input logic [1:0] cy, input logic [1:0] a,
                     input logic [15:0] y0, input logic [15:0] y1,
                     input logic [31:0] ep, input logic [31:0] eb0,
                     input logic [31:0] eb1, input logic eo,
                     input logic [1:0] es, input logic [1:0] er);
    vec_t v;
    v.en = e; v.abort = ab; v.per = p; v.bud0 = b0; v.bud1 = b1;
    v.carry = cy; v.ax = a; v.by0 = y0; v.by1 = y1;
    v.e_per = ep; v.e_b0 = eb0; v.e_b1 = eb1; v.e_over = eo;
    v.e_spent = es; v.e_ovr = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic ab, input logic [31:0] p,
                       input logic [31:0] b0, input logic [31:0] b1,
                       input logic [1:0] cy, input logic [1:0] a,
                       input logic [15:0] y0, input logic [15:0] y1);
    en = e; abort = ab; per = p; bud[0] = b0; bud[1] = b1;
    carry = cy; ax = a; bytes[0] = y0; bytes[1] = y1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " period_left"}, 64'(per_left), 64'd0);
    chk({tag, " budget_left0"}, 64'(bleft[0]), 64'd0);
    chk({tag, " budget_left1"}, 64'(bleft[1]), 64'd0);
    chk({tag, " spent"}, 64'(spent), 64'd3);
    chk({tag, " overrun"}, 64'(ovr), 64'd0);
    chk({tag, " period_over"}, 64'(over), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 16'd0, 16'd0);

    //   en ab per  bud0          bud1          cy    ax    by0 by1 | per  b0            b1            ov spent ovr
    add(1, 0, 10, 100,          50,           2'b00, 2'b00, 0,  0,   10,  100,          50,           1, 2'b00, 2'b00);
    add(1, 0, 10, 100,          50,           2'b00, 2'b01, 40, 0,   9,   60,           50,           0, 2'b00, 2'b00);
    add(1, 0, 10, 100,          50,           2'b00, 2'b01, 40, 0,   8,   20,           50,           0, 2'b00, 2'b00);
    add(1, 0, 10, 100,          50,           2'b00, 2'b01, 40, 0,   7,   0,            50,           0, 2'b01, 2'b01);
    add(1, 0, 10, 100,          50,           2'b00, 2'b11, 40, 10,  6,   0,            40,           0, 2'b01, 2'b01);
    add(0, 0, 10, 100,          50,           2'b00, 2'b11, 5,  5,   6,   0,            40,           0, 2'b01, 2'b01);
    for (int i = 5; i >= 0; i--)
      add(1, 0, 10, 100,        50,           2'b00, 2'b00, 0,  0,   i,   0,            40,           0, 2'b01, 2'b01);
    add(1, 0, 10, 100,          100,          2'b00, 2'b11, 25, 25,  10,  100,          75,           1, 2'b00, 2'b00);
    add(1, 0, 10, 100,          100,          2'b01, 2'b01, 30, 0,   9,   70,           75,           0, 2'b00, 2'b00);
    add(1, 0, 10, 100,          100,          2'b01, 2'b00, 0,  0,   8,   70,           75,           0, 2'b00, 2'b00);
    add(1, 0, 10, 100,          100,          2'b01, 2'b00, 0,  0,   7,   70,           75,           0, 2'b00, 2'b00);
    add(0, 1, 10, 100,          100,          2'b01, 2'b00, 0,  0,   10,  170,          100,          1, 2'b00, 2'b00);
    add(0, 0, 10, 100,          100,          2'b01, 2'b00, 0,  0,   10,  170,          100,          0, 2'b00, 2'b00);
    add(0, 1, 10, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 2'b01, 2'b00, 0, 0,  10,  32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 2'b00, 2'b00);
    add(1, 1, 10, 32'hFFFF_FFF0, 20,          2'b01, 2'b10, 0,  30,  10,  32'hFFFF_FFFF, 0,            1, 2'b10, 2'b10);
    add(1, 1, 0,  5,            7,            2'b00, 2'b00, 0,  0,   0,   5,            7,            1, 2'b00, 2'b00);
    add(1, 0, 0,  5,            7,            2'b00, 2'b01, 3,  0,   0,   2,            7,            1, 2'b00, 2'b00);
    add(1, 0, 0,  5,            7,            2'b00, 2'b01, 9,  0,   0,   0,            7,            1, 2'b01, 2'b01);

    step();
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].abort, vecs[i].per, vecs[i].bud0, vecs[i].bud1,
            vecs[i].carry, vecs[i].ax, vecs[i].by0, vecs[i].by1);
      step();
      chk($sformatf("v%0d period_left", i), 64'(per_left), 64'(vecs[i].e_per));
      chk($sformatf("v%0d budget_left0", i), 64'(bleft[0]), 64'(vecs[i].e_b0));
      chk($sformatf("v%0d budget_left1", i), 64'(bleft[1]), 64'(vecs[i].e_b1));
      chk($sformatf("v%0d period_over", i), 64'(over), 64'(vecs[i].e_over));
      chk($sformatf("v%0d spent", i), 64'(spent), 64'(vecs[i].e_spent));
      chk($sformatf("v%0d overrun", i), 64'(ovr), 64'(vecs[i].e_ovr));
    end

    // Channel 0 refilled to 50 while channel 1 overruns, then reset mid-period.
    drive(1'b1, 1'b0, 32'd10, 32'd50, 32'd5, 2'b00, 2'b10, 16'd0, 16'd9);
    step();
    chk("pre-rst period_left", 64'(per_left), 64'd10);
    chk("pre-rst budget_left0", 64'(bleft[0]), 64'd50);
    chk("pre-rst overrun", 64'(ovr), 64'd2);
    chk("pre-rst period_over", 64'(over), 64'd1);
    drive(1'b1, 1'b0, 32'd10, 32'd50, 32'd5, 2'b00, 2'b00, 16'd0, 16'd0);
    step();
    chk("mid period_left", 64'(per_left), 64'd9);
    chk("mid period_over", 64'(over), 64'd0);
    #3 rst = 1'b1;
    #1;
    chk_reset("async-rst");
    #2 rst = 1'b0;

    // Period spacing: with period 10 reloads are 11 enabled cycles apart.
    drive(1'b1, 1'b0, 32'd10, 32'd100, 32'd100, 2'b00, 2'b00, 16'd0, 16'd0);
    step();
    chk("first reload pulse", 64'(over), 64'd1);
    chk("first reload period", 64'(per_left), 64'd10);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (over) begin
        n = k;
        break;
      end
    end
    chk("reload spacing", 64'(n), 64'd11);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
